// File: rtl/ser_p2s.sv
`timescale 1ns/1ps
// ser_p2s: parallel-to-serial front end for the serial sequence detectors.
// A WIDTH-bit word is accepted over valid/ready and shifted out one bit per
// DIV clocks on sout. Back-to-back words stream without an idle gap.
// Optional build macro: SER_PARITY_EN appends one even-parity slot per word.
module ser_p2s #(
  parameter int WIDTH = 8,
  parameter int DIV   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic             msb_first,
  output logic             sout,
  output logic             sout_valid,
  output logic             busy
);

  localparam int BW = $clog2(WIDTH + 1);
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);
  localparam logic [BW-1:0] BIT_ONE  = BW'(1);
  localparam logic [DW-1:0] LAST_DIV = DW'(DIV - 1);
  localparam logic [DW-1:0] DIV_ONE  = DW'(1);

`ifdef SER_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PAR} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

  state_t           r_state,      w_state_nxt;
  logic [WIDTH-1:0] r_shift,      w_shift_nxt;
  logic [BW-1:0]    r_bit_cnt,    w_bit_cnt_nxt;
  logic [DW-1:0]    r_div_cnt,    w_div_cnt_nxt;
  logic             r_sout,       w_sout_nxt;
  logic             r_sout_valid, w_sout_valid_nxt;
`ifdef SER_PARITY_EN
  logic             r_par,        w_par_nxt;
`endif

  logic [WIDTH-1:0] w_din_load;
  logic             w_div_wrap;
  logic             w_last_slot;
  logic             w_accept;

  // Word as it enters the shift register: the head (MSB position) always
  // holds the next bit to send, so LSB-first words are loaded reversed.
  // The bit order chosen at accept is thereby frozen for the whole frame.
  always_comb begin
    w_din_load = din;
    if (!msb_first) begin
      for (int i = 0; i < WIDTH; i++) begin
        w_din_load[i] = din[WIDTH-1-i];
      end
    end
  end

  assign w_div_wrap = (r_div_cnt == LAST_DIV);

  // The final clock of the final slot of a frame; only here can a new word
  // be taken while busy, which is what allows gapless streaming.
`ifdef SER_PARITY_EN
  assign w_last_slot = (r_state == PAR) && w_div_wrap;
`else
  assign w_last_slot = (r_state == SHIFT) && (r_bit_cnt == LAST_BIT) && w_div_wrap;
`endif

  assign din_ready = (r_state == IDLE) || w_last_slot;
  assign w_accept  = din_valid && din_ready;

  // Next-state and next-output decode for the frame sequencer.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    w_state_nxt      = r_state;
    w_shift_nxt      = r_shift;
    w_bit_cnt_nxt    = r_bit_cnt;
    w_div_cnt_nxt    = r_div_cnt;
    w_sout_nxt       = r_sout;
    w_sout_valid_nxt = r_sout_valid;
`ifdef SER_PARITY_EN
    w_par_nxt        = r_par;
`endif

    if (w_accept) begin
      w_state_nxt      = SHIFT;
      w_shift_nxt      = w_din_load;
      w_bit_cnt_nxt    = '0;
      w_div_cnt_nxt    = '0;
      w_sout_nxt       = w_din_load[WIDTH-1];
      w_sout_valid_nxt = 1'b1;
`ifdef SER_PARITY_EN
      w_par_nxt        = ^din;
`endif
    end else begin
      case (r_state)
        SHIFT: begin
          if (w_div_wrap) begin
            w_div_cnt_nxt = '0;
            w_shift_nxt   = {r_shift[WIDTH-2:0], 1'b0};
            if (r_bit_cnt == LAST_BIT) begin
              w_bit_cnt_nxt = '0;
`ifdef SER_PARITY_EN
              w_state_nxt   = PAR;
              w_sout_nxt    = r_par;
`else
              w_state_nxt      = IDLE;
              w_sout_nxt       = 1'b0;
              w_sout_valid_nxt = 1'b0;
`endif
            end else begin
              w_bit_cnt_nxt = r_bit_cnt + BIT_ONE;
              w_sout_nxt    = r_shift[WIDTH-2];
            end
          end else begin
            w_div_cnt_nxt = r_div_cnt + DIV_ONE;
          end
        end
`ifdef SER_PARITY_EN
        PAR: begin
          if (w_div_wrap) begin
            w_state_nxt      = IDLE;
            w_div_cnt_nxt    = '0;
            w_sout_nxt       = 1'b0;
            w_sout_valid_nxt = 1'b0;
          end else begin
            w_div_cnt_nxt = r_div_cnt + DIV_ONE;
          end
        end
`endif
        default: begin
          w_sout_nxt       = 1'b0;
          w_sout_valid_nxt = 1'b0;
        end
      endcase
    end
  end

  // State and datapath registers; reset abandons any frame in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_shift      <= '0;
      r_bit_cnt    <= '0;
      r_div_cnt    <= '0;
      r_sout       <= 1'b0;
      r_sout_valid <= 1'b0;
`ifdef SER_PARITY_EN
      r_par        <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments keep every register updating from
      // the pre-edge values, independent of statement order.
      r_state      <= w_state_nxt;
      r_shift      <= w_shift_nxt;
      r_bit_cnt    <= w_bit_cnt_nxt;
      r_div_cnt    <= w_div_cnt_nxt;
      r_sout       <= w_sout_nxt;
      r_sout_valid <= w_sout_valid_nxt;
`ifdef SER_PARITY_EN
      r_par        <= w_par_nxt;
`endif
    end
  end

  assign sout       = r_sout;
  assign sout_valid = r_sout_valid;
  assign busy       = (r_state != IDLE);

endmodule

// File: doc/ser_p2s.md
# ser_p2s

Parallel-to-serial front end for the serial sequence detectors (e.g. the 101 detector). Accepts a WIDTH-bit word over a valid/ready handshake and emits it one bit at a time on `sout`, which drives the detector's serial `in`. Each bit is held for DIV clocks. Back-to-back words stream with no idle gap between them.

## Interface
- `WIDTH`, default 8: word width in bits, ≥2.
- `DIV`, default 1: clocks per serial bit, ≥1.
- `clk` input 1: clock, rising edge.
- `rst` input 1: reset, asynchronous, active-high.
- `din` input WIDTH: parallel word.
- `din_valid` input 1: `din` is valid.
- `din_ready` output 1: block can accept a word this cycle.
- `msb_first` input 1: bit order, sampled at accept; 1 = MSB first.
- `sout` output 1: serial bit, registered.
- `sout_valid` output 1: `sout` carries a frame bit, registered.
- `busy` output 1: a frame is in progress.

## Operation
- **FSM states:**
  - IDLE: no frame.
  - SHIFT: data bits.
  - PAR: parity slot, only with `SER_PARITY_EN`.
- **Accept:** occurs on a rising edge with `din_valid && din_ready`.
  - Latch `din` into the shift register (reversed when `msb_first`=0).
  - Latch `msb_first`.
  - Clear `bit_cnt` and `div_cnt`.
  - Go to SHIFT.
- **`din_ready`** is combinational: `(state==IDLE) || last_slot`.
  - `last_slot` = final `div_cnt` cycle of the final slot of the frame: data bit WIDTH-1, or the parity slot when enabled.
  - No other path to ready; words offered while busy are not consumed, and `din` must be held.
- **SHIFT:**
  - `sout` = current head bit; `sout_valid`=1.
  - `div_cnt` counts 0..DIV-1. On wrap, shift one position and increment `bit_cnt`.
  - After bit WIDTH-1 completes:
    - If a new accept occurs in the same cycle: reload, stay in SHIFT.
    - Else with parity enabled: go to PAR.
    - Else: go to IDLE.
- **PAR:** `sout` = XOR of the latched word (even parity); held DIV cycles. Then reload on accept, otherwise go to IDLE.
- **IDLE:** `sout`=0, `sout_valid`=0, `busy`=0.
- **`busy`** = 1 in SHIFT and PAR.
- **Counter widths:**
  - `bit_cnt`: $clog2(WIDTH+1).
  - `div_cnt`: $clog2(DIV), minimum 1 bit.
  - Neither counter passes its terminal value; wrap to 0.
- **Reset mid-frame:** the frame is abandoned immediately. No partial bits are resumed after release.

## Timing
- **Reset values:** state=IDLE, `sout`=0, `sout_valid`=0, `busy`=0. `din_ready`=1 while `rst` is high and after release.
- **Latency:** the first data bit appears on `sout`/`sout_valid` in the cycle after the accept edge (1 clk).
- **Frame length:**
  - Without parity: WIDTH·DIV cycles.
  - With parity: (WIDTH+1)·DIV cycles.
- **Back-to-back:** an accept in the `last_slot` cycle puts bit 0 of the new word on `sout` in the very next cycle, with `sout_valid` continuously 1.
- **Gap:** an accept any later costs at least one idle cycle with `sout_valid`=0.
- **Bit order:** `msb_first` changes after accept have no effect until the next accept.
- **DIV=1:** `last_slot` is the single cycle showing the last bit.

## Configuration
- **Macro `SER_PARITY_EN`:**
  - Defined: PAR state compiled in. One even-parity bit follows every word, `sout_valid`=1 during it, and `last_slot` moves to the parity slot.
  - Undefined: no PAR state and no parity logic. Frames are exactly WIDTH bits.

## Test plan
- **Basic frame:** WIDTH=8, DIV=1, `msb_first`=1, accept 8'hA5 at cycle 0 -> `sout`=1,0,1,0,0,1,0,1 on cycles 1..8, `sout_valid`=1 on 1..8, 0 at cycle 9. `din_ready`=0 on cycles 1..7, 1 on cycle 8.
- **LSB first:** `msb_first`=0, same word 8'hA5 -> `sout`=1,0,1,0,0,1,0,1 (palindrome check). Repeat with 8'h01 -> 1 then seven 0s.
- **Back-to-back:** `din_valid` held high with 8'hFF then 8'h00 -> 16 consecutive valid bits: eight 1s then eight 0s, no gap. Feed into seq101_3 with 8'h05 -> detector `out` pulses per its spec.
- **Clock divide:** DIV=3, 8'h80 MSB first -> `sout`=1 for cycles 1..3, 0 for cycles 4..24. `busy` deasserts at cycle 25.
- **Reset mid-frame:** assert `rst` at cycle 4 of an 8'hA5 frame -> `sout`, `sout_valid`, `busy` all 0 asynchronously, `din_ready`=1. A new accept after release starts from bit 0.
- **Parity (`SER_PARITY_EN` defined):**
  - 8'h07 -> 8 data bits then parity bit 1, 9 valid cycles.
  - 8'h03 -> parity bit 0.
  - `din_ready` rises only in the parity cycle.
